// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan master: per command, runs one UIR/CDR/SDR/E1DR sequence
// and returns the captured DR and the ir_out value.
module cpu_debug_scan_master #(
  parameter int TCK_DIV = 2,
  parameter int DR_LEN  = 38
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic [1:0]        rsp_ir_out,
  output logic              tck,
  output logic              tdi,
  output logic              vs_uir,
  output logic              vs_cdr,
  output logic              vs_sdr,
  output logic              vs_e1dr,
  output logic              jtag_state_rti,
  output logic [1:0]        ir_in,
  input  logic              tdo,
  input  logic [1:0]        ir_out
);

  localparam int DW = (TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
  localparam int BW = (DR_LEN > 1) ? $clog2(DR_LEN) : 1;
  localparam logic [DW-1:0] HALF_LAST = DW'(TCK_DIV - 1);
  localparam logic [DW-1:0] FULL_LAST = DW'(2 * TCK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    E1DR,
    DONE
  } state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DR_LEN-1:0] shift_reg;
  logic [DR_LEN-1:0] capture;
  logic [1:0]        ir_capture;

  // Captures land in private registers and are published at DONE, so the
  // response outputs stay stable across the whole next scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      shift_reg      <= '0;
      capture        <= '0;
      ir_capture     <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_dr         <= '0;
      rsp_ir_out     <= '0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_e1dr        <= 1'b0;
      jtag_state_rti <= 1'b1;
      ir_in          <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state          <= UIR;
            ir_in          <= cmd_ir;
            shift_reg      <= cmd_dr;
            cmd_ready      <= 1'b0;
            jtag_state_rti <= 1'b0;
            vs_uir         <= 1'b1;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            tck            <= 1'b0;
          end
        end
        UIR, CDR, SDR, E1DR: begin
          if (div_cnt == FULL_LAST) begin
            // End of a tck period: tck falls and the next period begins.
            div_cnt <= '0;
            tck     <= 1'b0;
            case (state)
              UIR: begin
                state  <= CDR;
                vs_uir <= 1'b0;
                vs_cdr <= 1'b1;
              end
              CDR: begin
                state   <= SDR;
                vs_cdr  <= 1'b0;
                vs_sdr  <= 1'b1;
                tdi     <= shift_reg[0];
                bit_cnt <= '0;
              end
              SDR: begin
                if (bit_cnt == BIT_LAST) begin
                  state   <= E1DR;
                  vs_sdr  <= 1'b0;
                  vs_e1dr <= 1'b1;
                  tdi     <= 1'b0;
                end else begin
                  bit_cnt   <= bit_cnt + 1'b1;
                  shift_reg <= {1'b0, shift_reg[DR_LEN-1:1]};
                  tdi       <= shift_reg[1];
                end
              end
              E1DR: begin
                state      <= DONE;
                vs_e1dr    <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_dr     <= capture;
                rsp_ir_out <= ir_capture;
              end
              default: ;
            endcase
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == HALF_LAST) begin
              tck <= 1'b1;
              if (state == UIR) ir_capture <= ir_out;
              if (state == SDR) capture <= {tdo, capture[DR_LEN-1:1]};
            end
          end
        end
        DONE: begin
          // Ready returns only once back in IDLE, the cycle after rsp_valid.
          state          <= IDLE;
          cmd_ready      <= 1'b1;
          jtag_state_rti <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Bench for cpu_debug_scan_master: vector table, random scans against a
// bit-stream model of the virtual-JTAG slave, and multi-cycle corner cases.
module tb_cpu_debug_scan_master;

  localparam int DR  = 38;
  localparam int DIV = 2;
  localparam int LAT = (DR + 3) * 2 * DIV;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, rsp_valid;
  logic [1:0]    cmd_ir, rsp_ir_out, ir_in, ir_out;
  logic [DR-1:0] cmd_dr, rsp_dr;
  logic          tck, tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_e1dr, rti;

  logic          cmd_valid8, cmd_ready8, rsp_valid8;
  logic [1:0]    cmd_ir8, rsp_ir_out8, ir_in8, ir_out8;
  logic [7:0]    cmd_dr8, rsp_dr8;
  logic          tck8, tdi8, vs_uir8, vs_cdr8, vs_sdr8, vs_e1dr8, rti8;

  int            tdo_mode;
  logic [DR-1:0] slave_bits;
  int            rise_idx;

  assign tdo = (tdo_mode == 0) ? tdi :
               (tdo_mode == 1) ? 1'b1 :
               ((rise_idx < DR) ? slave_bits[rise_idx[5:0]] : 1'b0);

  cpu_debug_scan_master #(.TCK_DIV(DIV), .DR_LEN(DR)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid), .rsp_dr(rsp_dr),
    .rsp_ir_out(rsp_ir_out), .tck(tck), .tdi(tdi), .vs_uir(vs_uir),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_e1dr(vs_e1dr), .jtag_state_rti(rti),
    .ir_in(ir_in), .tdo(tdo), .ir_out(ir_out)
  );

  cpu_debug_scan_master #(.TCK_DIV(1), .DR_LEN(8)) dut8 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8),
    .cmd_ir(cmd_ir8), .cmd_dr(cmd_dr8), .rsp_valid(rsp_valid8), .rsp_dr(rsp_dr8),
    .rsp_ir_out(rsp_ir_out8), .tck(tck8), .tdi(tdi8), .vs_uir(vs_uir8),
    .vs_cdr(vs_cdr8), .vs_sdr(vs_sdr8), .vs_e1dr(vs_e1dr8), .jtag_state_rti(rti8),
    .ir_in(ir_in8), .tdo(tdi8), .ir_out(ir_out8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scan monitor: measures periods, tck edges and the tdi bit stream per scan.
  int            acc_cyc, last_lat, rsp_count = 0;
  int            n_uir, n_cdr, n_e1dr, n_sdr_rise, onehot_err, tdi_stray;
  logic [DR-1:0] tdi_bits;
  logic          tck_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset && cmd_ready && cmd_valid) begin
      acc_cyc = cyc + 1;
      n_uir = 0; n_cdr = 0; n_e1dr = 0; n_sdr_rise = 0;
      onehot_err = 0; tdi_stray = 0; rise_idx = 0; tdi_bits = '0;
    end else begin
      if (vs_uir) n_uir++;
      if (vs_cdr) n_cdr++;
      if (vs_e1dr) n_e1dr++;
      if ($countones({vs_uir, vs_cdr, vs_sdr, vs_e1dr}) > 1) onehot_err++;
      if (!vs_sdr && tdi) tdi_stray++;
      if (tck && !tck_prev && vs_sdr) begin
        if (rise_idx < DR) tdi_bits[rise_idx[5:0]] = tdi;
        n_sdr_rise++;
        rise_idx++;
      end
      if (rsp_valid) begin
        rsp_count++;
        last_lat = cyc - acc_cyc;
      end
    end
    tck_prev = tck;
  end

  int         acc8_q[$], rsp8_q[$];
  logic [7:0] rsp8_dr_q[$];
  always @(negedge clk) begin
    if (!reset && cmd_ready8 && cmd_valid8) acc8_q.push_back(cyc + 1);
    if (rsp_valid8) begin
      rsp8_q.push_back(cyc);
      rsp8_dr_q.push_back(rsp_dr8);
    end
  end

  typedef struct {
    int            mode;
    logic [1:0]    ir;
    logic [1:0]    irout;
    logic [DR-1:0] dr;
    logic [DR-1:0] slave;
    logic [DR-1:0] exp_dr;
    logic [1:0]    exp_ir;
  } vec_t;

  vec_t vecs[4];
  int   tests = 0;
  int   fails = 0;
  int   base_rsp;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int mode, input logic [1:0] ir, input logic [1:0] irout,
                               input logic [DR-1:0] dr, input logic [DR-1:0] slave);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    tdo_mode   = mode;
    ir_out     = irout;
    slave_bits = slave;
    cmd_ir     = ir;
    cmd_dr     = dr;
    base_rsp   = rsp_count;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic waitRsp(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 1000 && !ok) begin
      @(negedge clk); #1;
      if (rsp_valid) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL rsp_timeout: got no rsp_valid, expected one within 1000 clks");
    end
  endtask

  task automatic finishScan(input logic [1:0] ir, input logic [DR-1:0] dr,
                            input logic [DR-1:0] exp_dr, input logic [1:0] exp_ir);
    checkOutput("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
    checkOutput("rsp_ir_out", 64'(rsp_ir_out), 64'(exp_ir));
    checkOutput("ir_in", 64'(ir_in), 64'(ir));
    checkOutput("latency", 64'(last_lat), 64'(LAT));
    checkOutput("sdr_rises", 64'(n_sdr_rise), 64'(DR));
    checkOutput("uir_clks", 64'(n_uir), 64'(2 * DIV));
    checkOutput("cdr_clks", 64'(n_cdr), 64'(2 * DIV));
    checkOutput("e1dr_clks", 64'(n_e1dr), 64'(2 * DIV));
    checkOutput("vs_onehot", 64'(onehot_err), 64'd0);
    checkOutput("tdi_outside_sdr", 64'(tdi_stray), 64'd0);
    checkOutput("tdi_stream", 64'(tdi_bits), 64'(dr));
    checkOutput("rsp_count", 64'(rsp_count - base_rsp), 64'd1);
    @(negedge clk); #1;
    checkOutput("rsp_pulse_width", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1;
    checkOutput("ready_after_done", 64'(cmd_ready), 64'd1);
    checkOutput("rti_after_done", 64'(rti), 64'd1);
    checkOutput("ir_in_retained", 64'(ir_in), 64'(ir));
  endtask

  task automatic runScan(input vec_t v);
    bit ok;
    applyStimulus(v.mode, v.ir, v.irout, v.dr, v.slave);
    waitRsp(ok);
    if (ok) finishScan(v.ir, v.dr, v.exp_dr, v.exp_ir);
  endtask

  task automatic waitRise(input int target);
    int n = 0;
    while (rise_idx < target && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("reach_sdr_bit", 64'(rise_idx >= target), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    bit   ok;
    int   n;
    logic [DR-1:0] held;

    vecs[0] = '{0, 2'b01, 2'b10, 38'h2A_5555_AAAA, 38'h0, 38'h2A_5555_AAAA, 2'b10};
    vecs[1] = '{1, 2'b11, 2'b01, 38'h0, 38'h0, 38'h3F_FFFF_FFFF, 2'b01};
    vecs[2] = '{2, 2'b10, 2'b11, 38'h15_0F0F_1234, 38'h00_0000_0001, 38'h00_0000_0001, 2'b11};
    vecs[3] = '{2, 2'b00, 2'b00, 38'h3F_FFFF_FFFF, 38'h20_0000_0000, 38'h20_0000_0000, 2'b00};

    reset = 1'b1; cmd_valid = 1'b0; cmd_ir = '0; cmd_dr = '0; ir_out = '0;
    tdo_mode = 0; slave_bits = '0; rise_idx = 0;
    cmd_valid8 = 1'b0; cmd_ir8 = 2'b10; cmd_dr8 = '0; ir_out8 = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset_rti", 64'(rti), 64'd1);
    checkOutput("reset_scan_pins", 64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr, rsp_valid}), 64'd0);
    checkOutput("reset_regs", 64'({ir_in, rsp_ir_out, rsp_dr}), 64'd0);
    reset = 1'b0;

    $display("[TB] vector table");
    foreach (vecs[i]) runScan(vecs[i]);

    $display("[TB] random scans");
    for (int i = 0; i < 6; i++) begin
      v.mode   = ($urandom_range(0, 1) == 1) ? 2 : 0;
      v.ir     = 2'($urandom_range(0, 3));
      v.irout  = 2'($urandom_range(0, 3));
      v.dr     = DR'({$urandom(), $urandom()});
      v.slave  = DR'({$urandom(), $urandom()});
      v.exp_dr = (v.mode == 0) ? v.dr : v.slave;
      v.exp_ir = v.irout;
      runScan(v);
    end

    $display("[TB] busy command drop");
    held = rsp_dr;
    applyStimulus(2, 2'b01, 2'b10, 38'h01_2345_6789, 38'h2B_CDEF_0123);
    waitRise(20);
    checkOutput("rsp_dr_held", 64'(rsp_dr), 64'(held));
    @(posedge clk); #1;
    cmd_ir = 2'b11; cmd_dr = 38'h3F_0000_FFFF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waitRsp(ok);
    if (ok) finishScan(2'b01, 38'h01_2345_6789, 38'h2B_CDEF_0123, 2'b10);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("busy_single_rsp", 64'(rsp_count - base_rsp), 64'd1);

    $display("[TB] reset mid-scan");
    applyStimulus(0, 2'b10, 2'b01, 38'h15_A5A5_3C3C, 38'h0);
    waitRise(11);
    reset = 1'b1; cmd_valid = 1'b1; cmd_ir = 2'b11; cmd_dr = 38'h3F_FFFF_FFFF;
    @(posedge clk); #1;
    checkOutput("abort_ready", 64'(cmd_ready), 64'd1);
    checkOutput("abort_rti", 64'(rti), 64'd1);
    checkOutput("abort_scan_pins", 64'({tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr, rsp_valid}), 64'd0);
    checkOutput("abort_regs", 64'({ir_in, rsp_ir_out, rsp_dr}), 64'd0);
    @(posedge clk); #1;
    checkOutput("no_accept_in_reset", 64'(cmd_ready), 64'd1);
    reset = 1'b0; cmd_valid = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("abort_no_rsp", 64'(rsp_count - base_rsp), 64'd0);
    runScan(vecs[0]);

    $display("[TB] back-to-back, TCK_DIV=1 DR_LEN=8");
    @(posedge clk); #1;
    cmd_dr8 = 8'hA5; cmd_valid8 = 1'b1;
    n = 0;
    while (acc8_q.size() < 1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_dr8 = 8'h3C;
    n = 0;
    while (acc8_q.size() < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    cmd_valid8 = 1'b0;
    n = 0;
    while (rsp8_q.size() < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("b2b_accepts", 64'(acc8_q.size()), 64'd2);
    checkOutput("b2b_rsps", 64'(rsp8_q.size()), 64'd2);
    if (acc8_q.size() == 2 && rsp8_q.size() == 2) begin
      checkOutput("b2b_lat1", 64'(rsp8_q[0] - acc8_q[0]), 64'd22);
      checkOutput("b2b_gap", 64'(acc8_q[1] - rsp8_q[0]), 64'd2);
      checkOutput("b2b_lat2", 64'(rsp8_q[1] - acc8_q[1]), 64'd22);
      checkOutput("b2b_dr1", 64'(rsp8_dr_q[0]), 64'h0A5);
      checkOutput("b2b_dr2", 64'(rsp8_dr_q[1]), 64'h03C);
    end
    checkOutput("b2b_ir_out", 64'(rsp_ir_out8), 64'h1);
    checkOutput("b2b_ir_in", 64'(ir_in8), 64'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_debug_scan_master.md
CPU_DEBUG_SCAN_MASTER -- requirements
Module: cpu_debug_scan_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, meaning tck half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter DR_LEN, default 38, meaning data-register scan length in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all logic sits on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  scan request present.
REQ-006 SHALL have port cmd_ready  output  1  block idle and able to accept a request.
REQ-007 SHALL have port cmd_ir  input  2  instruction to present on ir_in for the scan.
REQ-008 SHALL have port cmd_dr  input  DR_LEN  data to shift out, LSB first.
REQ-009 SHALL have port rsp_valid  output  1  one-clk pulse when the scan completes.
REQ-010 SHALL have port rsp_dr  output  DR_LEN  data captured from tdo.
REQ-011 SHALL have port rsp_ir_out  output  2  ir_out value sampled during the UIR period.
REQ-012 SHALL have ports tck, tdi, vs_uir, vs_cdr, vs_sdr, vs_e1dr, jtag_state_rti  output  1 each  virtual-JTAG scan signals driven toward the debug slave.
REQ-013 SHALL have port ir_in  output  2  instruction presented to the debug slave.
REQ-014 SHALL have ports tdo  input  1  and ir_out  input  2  returned by the debug slave.

Function
REQ-015 SHALL implement states IDLE, UIR, CDR, SDR, E1DR, DONE.
REQ-016 IDLE: cmd_ready=1, jtag_state_rti=1, tck=0, all vs_* = 0.
REQ-017 On cmd_valid&cmd_ready: latch cmd_ir into ir_in and cmd_dr into a DR_LEN shift register; go to UIR; cmd_ready=0 from the next cycle.
REQ-018 Each of UIR, CDR, E1DR and each SDR bit SHALL last one tck period of 2*TCK_DIV clks: tck low for TCK_DIV clks, then high for TCK_DIV clks.
REQ-019 The matching vs_* flag SHALL be 1 for the whole period of its state; jtag_state_rti=0 outside IDLE.
REQ-020 SDR SHALL last exactly DR_LEN periods; a bit counter counts 0..DR_LEN-1, then the FSM goes to E1DR.
REQ-021 tdi SHALL equal shift-register bit 0 and SHALL update only at the start of each SDR period (tck falling edge). tdi=0 outside SDR.
REQ-022 tdo SHALL be sampled on the clk where tck goes 0->1 in each SDR period and shifted into rsp_dr from the MSB, so the first sampled bit ends in rsp_dr[0].
REQ-023 ir_out SHALL be sampled into rsp_ir_out at the UIR tck rising point.
REQ-024 ir_in SHALL hold from UIR through DONE and SHALL retain its last value in IDLE.
REQ-025 DONE SHALL last one clk with rsp_valid=1, then go to IDLE. rsp_valid SHALL occur (DR_LEN+3)*2*TCK_DIV clks after the acceptance edge (164 at defaults).
REQ-026 rsp_dr and rsp_ir_out SHALL hold their values until the next DONE.
REQ-027 cmd_valid while busy SHALL be ignored; there is no queueing.
REQ-028 rsp_valid has no backpressure; the block SHALL NOT stall on the consumer.

Reset
REQ-029 reset=1 at any clk, including mid-scan, SHALL force IDLE on the next edge: cmd_ready=1, rsp_valid=0, tck=0, tdi=0, vs_*=0, jtag_state_rti=1, ir_in=0, rsp_dr=0, rsp_ir_out=0, counters=0.
REQ-030 A scan aborted by reset SHALL produce no rsp_valid.
REQ-031 A cmd_valid present while reset=1 SHALL NOT be accepted.

Verification
REQ-032 Loopback test: tdo tied to tdi, ir_out=2'b10, cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA. Required: ir_in=01, rsp_dr=38'h2A_5555_AAAA, rsp_ir_out=10, rsp_valid exactly 164 clks after accept.
REQ-033 Period check: count tck rising edges with vs_sdr=1. Required: 38 edges; vs_uir, vs_cdr and vs_e1dr are each high for exactly 4 clks; all vs_* are one-hot.
REQ-034 Constant tdo: tdo=1 with cmd_dr=0. Required: rsp_dr=38'h3F_FFFF_FFFF and tdi stays 0 throughout.
REQ-035 Busy drop: second cmd_valid pulsed mid-SDR. Required: ignored; exactly one rsp_valid.
REQ-036 Reset mid-scan: reset asserted at SDR bit 10. Required: next clk shows IDLE outputs (REQ-029) and no rsp_valid; a new scan afterwards completes normally.
REQ-037 TCK_DIV=1, DR_LEN=8, back-to-back commands with cmd_valid held high. Required: rsp_valid at 22 clks; second command accepted the clk after the first rsp_valid.
